// File: rtl/i2c_eeprom_target.sv
// I2C target that emulates a 24C16-class 2 KiB EEPROM.
// The device address is 1010_bbb, where bbb holds word address bits [10:8].
// SDA and SCL are oversampled in the clk domain, and bytes are served from an external
// synchronous RAM port. The target never stretches the clock.
module i2c_eeprom_target #(
   parameter logic [3:0] DEV_HI     = 4'b1010,
   parameter int         ADDR_W     = 11,
   parameter int         FILTER_LEN = 3,
   parameter int         PAGE_BITS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sda,
   input  logic              scl,
   output logic              sda_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK,
      READ_FETCH, RD_DATA, RD_ACK, IGNORE
   } state_t;

   logic                  sda_s1, sda_s2, scl_s1, scl_s2;
   logic [FILTER_LEN-1:0] sda_hist, scl_hist;
   logic                  sda_f, scl_f, sda_q, scl_q;
   logic                  scl_rise, scl_fall, start_det, stop_det;

   state_t                state, ack_next;
   logic [2:0]            bit_cnt;
   logic [1:0]            step;     // sub-phase inside ACK and fetch states
   logic [6:0]            shreg;    // low 7 bits of the byte being received or sent
   logic [7:0]            rx_byte;
   logic                  rnw;
   logic [ADDR_W-1:0]     pointer;

   // Synchronise both pads. A new level is accepted only after FILTER_LEN identical samples.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (!rst) begin
         sda_s1   <= 1'b1;
         sda_s2   <= 1'b1;
         scl_s1   <= 1'b1;
         scl_s2   <= 1'b1;
         sda_hist <= '1;
         scl_hist <= '1;
         sda_f    <= 1'b1;
         scl_f    <= 1'b1;
         sda_q    <= 1'b1;
         scl_q    <= 1'b1;
      end else begin
         sda_s1   <= sda;
         sda_s2   <= sda_s1;
         scl_s1   <= scl;
         scl_s2   <= scl_s1;
         sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_s2};
         scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_s2};
         if (&sda_hist)       sda_f <= 1'b1;
         else if (~|sda_hist) sda_f <= 1'b0;
         if (&scl_hist)       scl_f <= 1'b1;
         else if (~|scl_hist) scl_f <= 1'b0;
         sda_q    <= sda_f;
         scl_q    <= scl_f;
      end
   end

   assign scl_rise  =  scl_f & ~scl_q;
   assign scl_fall  = ~scl_f &  scl_q;
   assign start_det =  scl_f &  scl_q &  sda_q & ~sda_f;
   assign stop_det  =  scl_f &  scl_q & ~sda_q &  sda_f;
   assign rx_byte   = {shreg, sda_f};

   // Select the state that follows an acknowledge slot once SDA is released.
   always_comb begin
      // NOTE: default first so no path leaves ack_next unassigned (no latch).
      ack_next = WR_DATA;
      if (state == DEV_ACK) ack_next = rnw ? READ_FETCH : WORD_ADDR;
   end

   // Protocol FSM. STOP beats START, and both beat bit handling. All outputs are registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         step       <= '0;
         shreg      <= '0;
         rnw        <= 1'b0;
         pointer    <= '0;
         sda_enable <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         if (stop_det) begin
            state      <= IDLE;
            sda_enable <= 1'b0;
            busy       <= 1'b0;
         end else if (start_det) begin
            state      <= DEV_ADDR;
            bit_cnt    <= '0;
            sda_enable <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state)
               DEV_ADDR: if (scl_rise) begin
                  shreg   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (rx_byte[7:4] != DEV_HI) begin
                        state <= IGNORE;
                     end else begin
                        pointer[ADDR_W-1:8] <= rx_byte[ADDR_W-8:1];
                        rnw   <= rx_byte[0];
                        busy  <= 1'b1;
                        step  <= '0;
                        state <= DEV_ACK;
                     end
                  end
               end
               // Pull SDA low on the 8th SCL fall and release it on the 9th SCL fall.
               DEV_ACK, WORD_ACK, WR_ACK: if (scl_fall) begin
                  if (step == 2'd0) begin
                     sda_enable <= 1'b1;
                     step       <= 2'd1;
                  end else begin
                     sda_enable <= 1'b0;
                     step       <= 2'd0;
                     bit_cnt    <= '0;
                     state      <= ack_next;
                  end
               end
               WORD_ADDR: if (scl_rise) begin
                  shreg   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     pointer[7:0] <= rx_byte;
                     step         <= '0;
                     state        <= WORD_ACK;
                  end
               end
               WR_DATA: if (scl_rise) begin
                  shreg   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     mem_addr  <= pointer;
                     mem_wdata <= rx_byte;
                     mem_we    <= 1'b1;
                     pointer[PAGE_BITS-1:0] <= pointer[PAGE_BITS-1:0] + 1'b1;
                     step      <= '0;
                     state     <= WR_ACK;
                  end
               end
               // Strobe the RAM, wait one clk for the data, then put the MSB on SDA.
               READ_FETCH: begin
                  case (step)
                     2'd0: begin
                        mem_addr <= pointer;
                        mem_re   <= 1'b1;
                        step     <= 2'd1;
                     end
                     2'd1: step <= 2'd2;
                     default: begin
                        shreg      <= mem_rdata[6:0];
                        sda_enable <= ~mem_rdata[7];
                        bit_cnt    <= '0;
                        step       <= 2'd0;
                        state      <= RD_DATA;
                     end
                  endcase
               end
               RD_DATA: if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_enable <= 1'b0;
                     pointer    <= pointer + 1'b1;
                     step       <= 2'd0;
                     state      <= RD_ACK;
                  end else begin
                     sda_enable <= ~shreg[6];
                     shreg      <= {shreg[5:0], 1'b0};
                     bit_cnt    <= bit_cnt + 3'd1;
                  end
               end
               // A NACK ends the read. An ACK fetches the next byte after SCL goes low again.
               RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_f) state <= IGNORE;
                     else       step  <= 2'd1;
                  end else if (scl_fall && step == 2'd1) begin
                     step  <= 2'd0;
                     state <= READ_FETCH;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target. It acts as the bus controller and backs the
// target with a 2 KiB synchronous RAM model.
module tb_i2c_eeprom_target;

   localparam int Q = 8;   // quarter SCL period in clk cycles (SCL = clk/32)

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sda_c = 1'b1;
   logic        scl_c = 1'b1;
   logic        sda_line;
   logic        sda_enable, mem_we, mem_re, busy;
   logic [10:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   int tests = 0;
   int errors = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   int en_cnt = 0;
   logic [10:0] we_addr [0:31];
   logic [7:0]  we_data [0:31];
   logic [10:0] re_addr [0:31];
   logic [7:0]  ram [0:2047];

   assign sda_line = sda_c & ~sda_enable;

   always #5 clk = ~clk;

   i2c_eeprom_target dut (
      .clk        (clk),
      .rst        (rst),
      .sda        (sda_line),
      .scl        (scl_c),
      .sda_enable (sda_enable),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   // RAM model plus a log of every strobe.
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr]         <= mem_wdata;
         we_addr[we_cnt[4:0]]  <= mem_addr;
         we_data[we_cnt[4:0]]  <= mem_wdata;
         we_cnt                <= we_cnt + 1;
      end
      if (mem_re) begin
         mem_rdata             <= ram[mem_addr];
         re_addr[re_cnt[4:0]]  <= mem_addr;
         re_cnt                <= re_cnt + 1;
      end
      if (sda_enable) en_cnt <= en_cnt + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_c(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Generates both START and repeated START.
   task automatic i2c_start;
      sda_c = 1'b1; wait_c(Q);
      scl_c = 1'b1; wait_c(Q);
      sda_c = 1'b0; wait_c(Q);
      scl_c = 1'b0; wait_c(Q);
   endtask

   task automatic i2c_stop;
      sda_c = 1'b0; wait_c(Q);
      scl_c = 1'b1; wait_c(Q);
      sda_c = 1'b1; wait_c(Q);
   endtask

   // With glitch set, a 2-clk low pulse is put on SCL while it is high.
   task automatic write_bit(input logic b, input logic glitch);
      sda_c = b; wait_c(Q);
      scl_c = 1'b1; wait_c(Q);
      if (glitch) begin
         scl_c = 1'b0; wait_c(2);
         scl_c = 1'b1; wait_c(Q - 2);
      end else begin
         wait_c(Q);
      end
      scl_c = 1'b0; wait_c(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_c = 1'b1; wait_c(Q);
      scl_c = 1'b1; wait_c(Q);
      b = sda_line; wait_c(Q);
      scl_c = 1'b0; wait_c(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input int glitch_at, output logic ack);
      for (int i = 0; i < 8; i++) write_bit(b[7-i], i == glitch_at);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic nack);
      logic bit_v;
      for (int i = 0; i < 8; i++) begin
         read_bit(bit_v);
         b[7-i] = bit_v;
      end
      write_bit(nack, 1'b0);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d0, d1;
      int         e0, n;

      // Reset state
      wait_c(4);
      check("rst_sda_enable", 32'(sda_enable), 0);
      check("rst_mem_we",     32'(mem_we),     0);
      check("rst_mem_re",     32'(mem_re),     0);
      check("rst_busy",       32'(busy),       0);
      check("rst_mem_addr",   32'(mem_addr),   0);
      check("rst_mem_wdata",  32'(mem_wdata),  0);
      rst = 1'b1;
      wait_c(20);

      // 1: write 0x5A to 0x134
      i2c_start;
      write_byte(8'hA2, -1, ack); check("t1_ack_dev", 32'(ack), 0);
      check("t1_busy", 32'(busy), 1);
      write_byte(8'h34, -1, ack); check("t1_ack_word", 32'(ack), 0);
      write_byte(8'h5A, -1, ack); check("t1_ack_data", 32'(ack), 0);
      i2c_stop; wait_c(10);
      check("t1_we_cnt",  32'(we_cnt), 1);
      check("t1_we_addr", 32'(we_addr[0]), 'h134);
      check("t1_we_data", 32'(we_data[0]), 'h5A);
      check("t1_busy_stop", 32'(busy), 0);

      // 2: random read of 0x134
      i2c_start;
      write_byte(8'hA2, -1, ack);
      write_byte(8'h34, -1, ack);
      i2c_start;
      write_byte(8'hA3, -1, ack); check("t2_ack_rd", 32'(ack), 0);
      read_byte(d0, 1'b1);
      i2c_stop; wait_c(10);
      check("t2_data",    32'(d0), 'h5A);
      check("t2_re_cnt",  32'(re_cnt), 1);
      check("t2_re_addr", 32'(re_addr[0]), 'h134);
      check("t2_we_cnt",  32'(we_cnt), 1);

      // 3: page wrap 0x00E, 0x00F, 0x000
      i2c_start;
      write_byte(8'hA0, -1, ack);
      write_byte(8'h0E, -1, ack);
      write_byte(8'h11, -1, ack);
      write_byte(8'h22, -1, ack);
      write_byte(8'h33, -1, ack); check("t3_ack_last", 32'(ack), 0);
      i2c_stop; wait_c(10);
      check("t3_we_cnt", 32'(we_cnt), 4);
      check("t3_addr0",  32'(we_addr[1]), 'h00E);
      check("t3_addr1",  32'(we_addr[2]), 'h00F);
      check("t3_addr2",  32'(we_addr[3]), 'h000);
      check("t3_data2",  32'(we_data[3]), 'h33);

      // 4: read wrap 0x7FF -> 0x000, after placing 0xC6 at 0x7FF
      i2c_start;
      write_byte(8'hAE, -1, ack);
      write_byte(8'hFF, -1, ack);
      write_byte(8'hC6, -1, ack);
      i2c_stop; wait_c(10);
      check("t4_we_addr", 32'(we_addr[4]), 'h7FF);
      i2c_start;
      write_byte(8'hAE, -1, ack);
      write_byte(8'hFF, -1, ack);
      i2c_start;
      write_byte(8'hAF, -1, ack);
      read_byte(d0, 1'b0);
      read_byte(d1, 1'b1);
      check("t4_sda_released", 32'(sda_enable), 0);
      i2c_stop; wait_c(10);
      check("t4_data0",   32'(d0), 'hC6);
      check("t4_data1",   32'(d1), 'h33);
      check("t4_re_cnt",  32'(re_cnt), 3);
      check("t4_re_addr0", 32'(re_addr[1]), 'h7FF);
      check("t4_re_addr1", 32'(re_addr[2]), 'h000);
      check("t4_busy",    32'(busy), 0);

      // 5: foreign address is ignored
      e0 = en_cnt;
      i2c_start;
      write_byte(8'h90, -1, ack); check("t5_nack", 32'(ack), 1);
      check("t5_busy", 32'(busy), 0);
      i2c_stop; wait_c(10);
      check("t5_no_drive", 32'(en_cnt - e0), 0);
      check("t5_we_cnt",   32'(we_cnt), 5);
      check("t5_re_cnt",   32'(re_cnt), 3);

      // 6: STOP after 3 data bits commits nothing
      i2c_start;
      write_byte(8'hA2, -1, ack);
      write_byte(8'h50, -1, ack);
      write_bit(1'b1, 1'b0);
      write_bit(1'b0, 1'b0);
      write_bit(1'b1, 1'b0);
      i2c_stop; wait_c(10);
      check("t6_we_cnt", 32'(we_cnt), 5);
      check("t6_busy",   32'(busy), 0);

      // 7: short SCL glitch inside a data byte is filtered out
      i2c_start;
      write_byte(8'hA2, -1, ack);
      write_byte(8'h40, -1, ack);
      write_byte(8'h3C, 3, ack); check("t7_ack", 32'(ack), 0);
      i2c_stop; wait_c(10);
      check("t7_we_cnt",  32'(we_cnt), 6);
      check("t7_we_addr", 32'(we_addr[5]), 'h140);
      check("t7_we_data", 32'(we_data[5]), 'h3C);

      // 8: reset in the middle of a read releases SDA on the next clk
      i2c_start;
      write_byte(8'hA2, -1, ack);
      write_byte(8'h34, -1, ack);
      i2c_start;
      write_byte(8'hA3, -1, ack);
      n = 0;
      while (!sda_enable && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("t8_drive_seen", 32'(sda_enable), 1);
      rst = 1'b0;
      @(negedge clk);
      check("t8_rst_sda", 32'(sda_enable), 0);
      check("t8_rst_busy", 32'(busy), 0);
      wait_c(4);
      rst = 1'b1;
      wait_c(10);
      i2c_stop; wait_c(10);
      i2c_start;
      write_byte(8'hA2, -1, ack); check("t8_recover_ack", 32'(ack), 0);
      i2c_stop; wait_c(10);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
